// File: rtl/sys_ctrl_pkg.sv
// Shared command codes and FSM state encoding for the command controller.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR  = 8'hAA;
  localparam logic [7:0] CMD_RD  = 8'hBB;
  localparam logic [7:0] CMD_OP  = 8'hCC;
  localparam logic [7:0] CMD_FUN = 8'hDD;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_WR_ADDR     = 4'd1,
    ST_WR_DATA     = 4'd2,
    ST_RD_ADDR     = 4'd3,
    ST_RD_WAIT     = 4'd4,
    ST_OP_A        = 4'd5,
    ST_OP_B        = 4'd6,
    ST_OP_FUN      = 4'd7,
    ST_SETTLE_WAIT = 4'd8,
    ST_ALU_WAIT    = 4'd9,
    ST_TX_PUSH     = 4'd10
  } state_e;

  // States in which an idle cycle advances the timeout counter.
  function automatic logic tmo_counts(input state_e s);
    return (s != ST_IDLE) && (s != ST_TX_PUSH);
  endfunction

endpackage

// File: rtl/tx_serializer.sv
// Splits a captured ALU_W word into DATA_W bytes, LSB first, pushing one byte
// per cycle while the TX FIFO has room.
module tx_serializer #(
  parameter int DATA_W = 8,
  parameter int ALU_W  = 16,
  parameter int CW     = $clog2(ALU_W / DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ALU_W-1:0]  load_data,
  input  logic [CW-1:0]     load_cnt,
  input  logic              fifo_full,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_inc,
  output logic              empty
);

  logic [ALU_W-1:0]  shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_inc_q, wr_inc_d;

  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    wr_data_d = wr_data_q;
    wr_inc_d  = 1'b0;
    if (load) begin
      shift_d = load_data;
      cnt_d   = load_cnt;
    end else if ((cnt_q != '0) && !fifo_full) begin
      wr_inc_d  = 1'b1;
      wr_data_d = shift_q[DATA_W-1:0];
      shift_d   = shift_q >> DATA_W;
      cnt_d     = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      wr_data_q <= '0;
      wr_inc_q  <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      wr_data_q <= wr_data_d;
      wr_inc_q  <= wr_inc_d;
    end
  end

  assign wr_data = wr_data_q;
  assign wr_inc  = wr_inc_q;
  assign empty   = (cnt_q == '0);

endmodule

// File: rtl/cmd_ctrl.sv
// Byte-command controller: register-file read/write, ALU operation sequencing
// with clock-gate settle time, and serialized TX of results.
//
// state          | meaning
// ST_IDLE        | waiting for a command byte
// ST_WR_ADDR     | waiting for register write address
// ST_WR_DATA     | waiting for register write data
// ST_RD_ADDR     | waiting for register read address
// ST_RD_WAIT     | read strobed, waiting for Rd_Valid
// ST_OP_A        | waiting for operand A (stored at address 0)
// ST_OP_B        | waiting for operand B (stored at address 1)
// ST_OP_FUN      | waiting for ALU function byte
// ST_SETTLE_WAIT | Gate_En high, waiting before raising EN
// ST_ALU_WAIT    | EN high, waiting for OUT_VALID
// ST_TX_PUSH     | pushing result bytes into the TX FIFO
module cmd_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int FUN_W   = 4,
  parameter int ALU_W   = 16,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] Data_sync,
  input  logic              enable_pulse,
  input  logic              FIFO_FULL,
  input  logic [DATA_W-1:0] Rd_DATA,
  input  logic              Rd_Valid,
  input  logic [ALU_W-1:0]  ALU_OUT,
  input  logic              OUT_VALID,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              WR_INC,
  output logic [FUN_W-1:0]  FUN,
  output logic              EN,
  output logic              Gate_En,
  output logic [DATA_W-1:0] Wr_D,
  output logic [ADDR_W-1:0] Addr,
  output logic              RdEn,
  output logic              WrEn,
  output logic              BUSY,
  output logic              ERR
);

  localparam int NB = ALU_W / DATA_W;
  localparam int CW = $clog2(NB + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e            state_q, state_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_d_q, wr_d_d;
  logic [FUN_W-1:0]  fun_q, fun_d;
  logic              en_q, en_d;
  logic              gate_q, gate_d;
  logic              rden_q, rden_d;
  logic              wren_q, wren_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              expire, abort;
  logic              ser_load, ser_empty;
  logic [ALU_W-1:0]  ser_data;
  logic [CW-1:0]     ser_cnt;

  // Abort on the cycle the idle count would reach TIMEOUT.
  assign expire = (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    addr_d   = addr_q;
    wr_d_d   = wr_d_q;
    fun_d    = fun_q;
    en_d     = en_q;
    gate_d   = gate_q;
    rden_d   = 1'b0;
    wren_d   = 1'b0;
    err_d    = 1'b0;
    abort    = 1'b0;
    ser_load = 1'b0;
    ser_data = '0;
    ser_cnt  = '0;

    case (state_q)
      ST_IDLE: begin
        if (enable_pulse) begin
          case (Data_sync)
            DATA_W'(CMD_WR):  state_d = ST_WR_ADDR;
            DATA_W'(CMD_RD):  state_d = ST_RD_ADDR;
            DATA_W'(CMD_OP):  state_d = ST_OP_A;
            DATA_W'(CMD_FUN): state_d = ST_OP_FUN;
            default:          err_d   = 1'b1;
          endcase
        end
      end
      ST_WR_ADDR: begin
        if (enable_pulse) begin
          addr_d  = Data_sync[ADDR_W-1:0];
          state_d = ST_WR_DATA;
        end else if (expire) abort = 1'b1;
      end
      ST_WR_DATA: begin
        if (enable_pulse) begin
          wr_d_d  = Data_sync;
          wren_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (expire) abort = 1'b1;
      end
      ST_RD_ADDR: begin
        if (enable_pulse) begin
          addr_d  = Data_sync[ADDR_W-1:0];
          rden_d  = 1'b1;
          state_d = ST_RD_WAIT;
        end else if (expire) abort = 1'b1;
      end
      ST_RD_WAIT: begin
        if (Rd_Valid) begin
          ser_load = 1'b1;
          ser_data = ALU_W'(Rd_DATA);
          ser_cnt  = CW'(1);
          state_d  = ST_TX_PUSH;
        end else if (expire) abort = 1'b1;
      end
      ST_OP_A: begin
        if (enable_pulse) begin
          addr_d  = '0;
          wr_d_d  = Data_sync;
          wren_d  = 1'b1;
          state_d = ST_OP_B;
        end else if (expire) abort = 1'b1;
      end
      ST_OP_B: begin
        if (enable_pulse) begin
          addr_d  = ADDR_W'(1);
          wr_d_d  = Data_sync;
          wren_d  = 1'b1;
          state_d = ST_OP_FUN;
        end else if (expire) abort = 1'b1;
      end
      ST_OP_FUN: begin
        if (enable_pulse) begin
          fun_d  = Data_sync[FUN_W-1:0];
          gate_d = 1'b1;
          if (SETTLE == 0) begin
            en_d    = 1'b1;
            state_d = ST_ALU_WAIT;
          end else begin
            settle_d = SW'(SETTLE - 1);
            state_d  = ST_SETTLE_WAIT;
          end
        end else if (expire) abort = 1'b1;
      end
      ST_SETTLE_WAIT: begin
        if (settle_q == '0) begin
          en_d    = 1'b1;
          state_d = ST_ALU_WAIT;
        end else if (expire) abort = 1'b1;
        else settle_d = settle_q - SW'(1);
      end
      ST_ALU_WAIT: begin
        if (OUT_VALID) begin
          en_d     = 1'b0;
          gate_d   = 1'b0;
          ser_load = 1'b1;
          ser_data = ALU_OUT;
          ser_cnt  = CW'(NB);
          state_d  = ST_TX_PUSH;
        end else if (expire) abort = 1'b1;
      end
      ST_TX_PUSH: begin
        if (ser_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      en_d    = 1'b0;
      gate_d  = 1'b0;
      rden_d  = 1'b0;
      wren_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);

    if (state_d != state_q)      tmo_d = '0;
    else if (tmo_counts(state_q)) tmo_d = tmo_q + TW'(1);
    else                          tmo_d = '0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      tmo_q    <= '0;
      settle_q <= '0;
      addr_q   <= '0;
      wr_d_q   <= '0;
      fun_q    <= '0;
      en_q     <= 1'b0;
      gate_q   <= 1'b0;
      rden_q   <= 1'b0;
      wren_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      settle_q <= settle_d;
      addr_q   <= addr_d;
      wr_d_q   <= wr_d_d;
      fun_q    <= fun_d;
      en_q     <= en_d;
      gate_q   <= gate_d;
      rden_q   <= rden_d;
      wren_q   <= wren_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  tx_serializer #(
    .DATA_W (DATA_W),
    .ALU_W  (ALU_W),
    .CW     (CW)
  ) u_tx (
    .clk       (CLK),
    .rst_n     (RST),
    .load      (ser_load),
    .load_data (ser_data),
    .load_cnt  (ser_cnt),
    .fifo_full (FIFO_FULL),
    .wr_data   (WR_DATA),
    .wr_inc    (WR_INC),
    .empty     (ser_empty)
  );

  assign FUN     = fun_q;
  assign EN      = en_q;
  assign Gate_En = gate_q;
  assign Wr_D    = wr_d_q;
  assign Addr    = addr_q;
  assign RdEn    = rden_q;
  assign WrEn    = wren_q;
  assign BUSY    = busy_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_cmd_ctrl.sv
// Self-checking bench for cmd_ctrl: vector table plus hand sequences for
// backpressure, timeout, byte-vs-timeout priority and mid-operation reset.
module tb_cmd_ctrl;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int FUN_W   = 4;
  localparam int ALU_W   = 16;
  localparam int SETTLE  = 2;
  localparam int TIMEOUT = 15;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic [DATA_W-1:0] Data_sync = '0;
  logic              enable_pulse = 1'b0;
  logic              FIFO_FULL = 1'b0;
  logic [DATA_W-1:0] Rd_DATA = '0;
  logic              Rd_Valid = 1'b0;
  logic [ALU_W-1:0]  ALU_OUT = '0;
  logic              OUT_VALID = 1'b0;
  logic [DATA_W-1:0] WR_DATA;
  logic              WR_INC;
  logic [FUN_W-1:0]  FUN;
  logic              EN;
  logic              Gate_En;
  logic [DATA_W-1:0] Wr_D;
  logic [ADDR_W-1:0] Addr;
  logic              RdEn;
  logic              WrEn;
  logic              BUSY;
  logic              ERR;

  cmd_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FUN_W(FUN_W),
    .ALU_W(ALU_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RST(RST), .Data_sync(Data_sync), .enable_pulse(enable_pulse),
    .FIFO_FULL(FIFO_FULL), .Rd_DATA(Rd_DATA), .Rd_Valid(Rd_Valid),
    .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID), .WR_DATA(WR_DATA), .WR_INC(WR_INC),
    .FUN(FUN), .EN(EN), .Gate_En(Gate_En), .Wr_D(Wr_D), .Addr(Addr),
    .RdEn(RdEn), .WrEn(WrEn), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int chk_cnt = 0;
  int fail_cnt = 0;
  int err_seen = 0;
  int push_cnt = 0;
  int wren_cnt = 0;
  int cyc = 0;
  int gate_rise = 0;
  logic gate_prev = 1'b0;
  logic en_prev = 1'b0;

  logic [7:0]  exp_tx_q[$];
  logic [11:0] exp_wr_q[$];
  logic [3:0]  exp_rd_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    chk_cnt++;
    fail_cnt++;
    $display("FAIL %s: got event with value %0h, expected none", name, act);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    Data_sync    = b;
    enable_pulse = 1'b1;
    step();
    enable_pulse = 1'b0;
  endtask

  // Scoreboard monitor: every strobe pops and compares one expected entry.
  always @(negedge CLK) begin
    cyc++;
    if (Gate_En && !gate_prev) gate_rise = cyc;
    if (EN && !en_prev) check("en_after_gate", cyc - gate_rise, SETTLE);
    gate_prev = Gate_En;
    en_prev   = EN;
    if (ERR) err_seen++;
    if (WR_INC) begin
      push_cnt++;
      if (exp_tx_q.size() == 0) unexpected("tx_push", {24'h0, WR_DATA});
      else check("tx_byte", {24'h0, WR_DATA}, {24'h0, exp_tx_q.pop_front()});
    end
    if (WrEn) begin
      wren_cnt++;
      if (exp_wr_q.size() == 0) unexpected("reg_write", {20'h0, Addr, Wr_D});
      else check("reg_write", {20'h0, Addr, Wr_D}, {20'h0, exp_wr_q.pop_front()});
    end
    if (RdEn) begin
      if (exp_rd_q.size() == 0) unexpected("reg_read", {28'h0, Addr});
      else check("reg_read_addr", {28'h0, Addr}, {28'h0, exp_rd_q.pop_front()});
    end
  end

  typedef struct {
    logic [31:0] seq;
    int          nb;
    int          kind;      // 0 none, 1 register read response, 2 ALU response
    logic [15:0] resp;
    int          nwr;
    logic [11:0] wr0;
    logic [11:0] wr1;
    int          nrd;
    logic [3:0]  rd_addr;
    int          ntx;
    logic [7:0]  tx0;
    logic [7:0]  tx1;
    logic [3:0]  fun;
    int          nerr;
    logic [3:0]  addr_end;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    int e0;
    int w0;
    int p0;

    vecs[0] = '{32'hAA053C00, 3, 0, 16'h0000, 1, 12'h53C, 12'h000, 0, 4'h0, 0, 8'h00, 8'h00, 4'h0, 0, 4'h5};
    vecs[1] = '{32'hBB020000, 2, 1, 16'h007E, 0, 12'h000, 12'h000, 1, 4'h2, 1, 8'h7E, 8'h00, 4'h0, 0, 4'h2};
    vecs[2] = '{32'hCC0A0B02, 4, 2, 16'h006E, 2, 12'h00A, 12'h10B, 0, 4'h0, 2, 8'h6E, 8'h00, 4'h2, 0, 4'h1};
    vecs[3] = '{32'h55000000, 1, 0, 16'h0000, 0, 12'h000, 12'h000, 0, 4'h0, 0, 8'h00, 8'h00, 4'h0, 1, 4'h1};
    vecs[4] = '{32'hAA1F8100, 3, 0, 16'h0000, 1, 12'hF81, 12'h000, 0, 4'h0, 0, 8'h00, 8'h00, 4'h0, 0, 4'hF};
    vecs[5] = '{32'hDD370000, 2, 2, 16'h1234, 0, 12'h000, 12'h000, 0, 4'h0, 2, 8'h34, 8'h12, 4'h7, 0, 4'hF};

    repeat (3) @(posedge CLK);
    #1;
    check("reset_outputs", {WR_DATA, WR_INC, FUN, EN, Gate_En, Wr_D, Addr, RdEn, WrEn, BUSY, ERR}, 0);
    RST = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      e0 = err_seen;
      if (vecs[v].nwr > 0) exp_wr_q.push_back(vecs[v].wr0);
      if (vecs[v].nwr > 1) exp_wr_q.push_back(vecs[v].wr1);
      if (vecs[v].nrd > 0) exp_rd_q.push_back(vecs[v].rd_addr);
      if (vecs[v].ntx > 0) exp_tx_q.push_back(vecs[v].tx0);
      if (vecs[v].ntx > 1) exp_tx_q.push_back(vecs[v].tx1);
      for (int k = 0; k < vecs[v].nb; k++) send_byte(vecs[v].seq[31-8*k -: 8]);
      if (vecs[v].kind == 1) begin
        step();
        step();
        Rd_DATA  = vecs[v].resp[7:0];
        Rd_Valid = 1'b1;
        step();
        Rd_Valid = 1'b0;
      end else if (vecs[v].kind == 2) begin
        n = 0;
        while (!EN && n < 20) begin step(); n++; end
        check("vec_en_raised", {31'h0, EN}, 1);
        check("vec_fun", {28'h0, FUN}, {28'h0, vecs[v].fun});
        ALU_OUT   = vecs[v].resp;
        OUT_VALID = 1'b1;
        step();
        OUT_VALID = 1'b0;
      end
      n = 0;
      while (BUSY && n < 20) begin step(); n++; end
      step();
      step();
      check("vec_busy_low", {31'h0, BUSY}, 0);
      check("vec_err_pulses", err_seen - e0, vecs[v].nerr);
      check("vec_addr_hold", {28'h0, Addr}, {28'h0, vecs[v].addr_end});
      check("vec_tx_drained", exp_tx_q.size(), 0);
      check("vec_wr_drained", exp_wr_q.size(), 0);
      check("vec_rd_drained", exp_rd_q.size(), 0);
      exp_tx_q.delete();
      exp_wr_q.delete();
      exp_rd_q.delete();
    end

    // Backpressure: FIFO full before the result lands and again between bytes.
    p0 = push_cnt;
    exp_tx_q.push_back(8'hCD);
    exp_tx_q.push_back(8'hAB);
    send_byte(8'hDD);
    send_byte(8'h07);
    n = 0;
    while (!EN && n < 20) begin step(); n++; end
    check("bp_en_raised", {31'h0, EN}, 1);
    FIFO_FULL = 1'b1;
    ALU_OUT   = 16'hABCD;
    OUT_VALID = 1'b1;
    step();
    OUT_VALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_stall_no_push", {31'h0, WR_INC}, 0);
    end
    FIFO_FULL = 1'b0;
    n = 0;
    while (!WR_INC && n < 10) begin step(); n++; end
    check("bp_first_push", {31'h0, WR_INC}, 1);
    FIFO_FULL = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("bp_midstall_no_push", {31'h0, WR_INC}, 0);
    end
    FIFO_FULL = 1'b0;
    n = 0;
    while (BUSY && n < 20) begin step(); n++; end
    step();
    step();
    check("bp_push_count", push_cnt - p0, 2);
    check("bp_tx_drained", exp_tx_q.size(), 0);
    check("bp_busy_low", {31'h0, BUSY}, 0);
    exp_tx_q.delete();

    // Timeout: write command then silence.
    e0 = err_seen;
    w0 = wren_cnt;
    send_byte(8'hAA);
    n = 0;
    while (!ERR && n < 40) begin step(); n++; end
    check("tmo_cycles", n, TIMEOUT);
    check("tmo_busy_low", {31'h0, BUSY}, 0);
    step();
    check("tmo_err_one_cycle", {31'h0, ERR}, 0);
    check("tmo_err_count", err_seen - e0, 1);
    check("tmo_no_write", wren_cnt - w0, 0);

    // A byte arriving on the expiry cycle wins over the timeout.
    e0 = err_seen;
    exp_wr_q.push_back(12'h95A);
    send_byte(8'hAA);
    repeat (TIMEOUT - 1) step();
    send_byte(8'h09);
    send_byte(8'h5A);
    step();
    step();
    check("prio_no_err", err_seen - e0, 0);
    check("prio_wr_drained", exp_wr_q.size(), 0);
    exp_wr_q.delete();

    // Reset asserted while waiting on the ALU.
    p0 = push_cnt;
    exp_wr_q.push_back(12'h001);
    exp_wr_q.push_back(12'h102);
    send_byte(8'hCC);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    n = 0;
    while (!EN && n < 20) begin step(); n++; end
    check("rst_en_raised", {31'h0, EN}, 1);
    RST = 1'b0;
    #1;
    check("rst_outputs_zero", {WR_DATA, WR_INC, FUN, EN, Gate_En, Wr_D, Addr, RdEn, WrEn, BUSY, ERR}, 0);
    step();
    step();
    RST = 1'b1;
    w0 = wren_cnt;
    repeat (10) step();
    check("rst_no_push", push_cnt - p0, 0);
    check("rst_no_write", wren_cnt - w0, 0);
    check("rst_busy_low", {31'h0, BUSY}, 0);
    check("rst_wr_drained", exp_wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/cmd_ctrl.md
CMD_CTRL -- requirements
Module: cmd_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning width of command, data, register-file and FIFO bytes.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning register-file address width.
REQ-003 SHALL have parameter FUN_W, default 4, meaning ALU function code width.
REQ-004 SHALL have parameter ALU_W, default 16, meaning ALU result width, an integer multiple of DATA_W.
REQ-005 SHALL have parameter SETTLE, default 2, meaning number of cycles between Gate_En rising and EN rising.
REQ-006 SHALL have parameter TIMEOUT, default 1023, meaning idle-cycle limit inside any non-IDLE state.
REQ-007 SHALL have these ports (name, direction, width, meaning):
- CLK  in  1  clock; one clock domain.
- RST  in  1  reset, asynchronous, active-low.
- Data_sync  in  DATA_W  received byte.
- enable_pulse  in  1  Data_sync valid for one cycle.
- FIFO_FULL  in  1  TX FIFO full.
- Rd_DATA  in  DATA_W  register-file read data.
- Rd_Valid  in  1  Rd_DATA valid.
- ALU_OUT  in  ALU_W  ALU result.
- OUT_VALID  in  1  ALU_OUT valid.
- WR_DATA  out  DATA_W  FIFO write byte.
- WR_INC  out  1  FIFO push strobe.
- FUN  out  FUN_W  ALU function.
- EN  out  1  ALU enable.
- Gate_En  out  1  ALU clock-gate enable.
- Wr_D  out  DATA_W  register-file write data.
- Addr  out  ADDR_W  register-file address.
- RdEn  out  1  register-file read strobe.
- WrEn  out  1  register-file write strobe.
- BUSY  out  1  high in every state except IDLE.
- ERR  out  1  one-cycle pulse on a timeout abort or an unknown command.

Function
REQ-008 SHALL drive every output from a flop; no latches and no combinational outputs.
REQ-009 SHALL use these states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, OP_FUN, SETTLE_WAIT, ALU_WAIT, TX_PUSH.
REQ-010 SHALL decode commands in IDLE on enable_pulse:
- 0xAA -> WR_ADDR.
- 0xBB -> RD_ADDR.
- 0xCC -> OP_A.
- 0xDD -> OP_FUN.
- Any other byte -> stay IDLE and pulse ERR.
REQ-011 SHALL, in WR_ADDR on a byte, latch Addr = byte[ADDR_W-1:0] and go to WR_DATA.
REQ-012 SHALL, in WR_DATA on a byte, set Wr_D = byte with WrEn high exactly one cycle (the cycle after the byte), then go to IDLE.
REQ-013 SHALL, in RD_ADDR on a byte, latch Addr, pulse RdEn for one cycle and go to RD_WAIT.
REQ-014 SHALL, in RD_WAIT on Rd_Valid, capture Rd_DATA as the single TX byte and go to TX_PUSH.
REQ-015 SHALL, in OP_A on a byte, write the byte to Addr 0 (one-cycle WrEn) and go to OP_B.
REQ-016 SHALL, in OP_B on a byte, write the byte to Addr 1 (one-cycle WrEn) and go to OP_FUN.
REQ-017 SHALL, in OP_FUN on a byte, latch FUN = byte[FUN_W-1:0], set Gate_En = 1 and go to SETTLE_WAIT.
REQ-018 SHALL raise EN exactly SETTLE cycles after Gate_En rises, then go to ALU_WAIT.
REQ-019 SHALL, in ALU_WAIT on OUT_VALID, capture ALU_OUT, drop EN and Gate_En, and go to TX_PUSH with ALU_W/DATA_W bytes queued.
REQ-020 SHALL, in TX_PUSH, push bytes least-significant first: WR_INC = 1 with WR_DATA = current byte on each cycle FIFO_FULL is low; WR_INC = 0 while FIFO_FULL is high; byte order is preserved across stalls.
REQ-021 SHALL go to IDLE in the cycle after the last byte is pushed.
REQ-022 SHALL ignore (drop) enable_pulse in RD_WAIT, SETTLE_WAIT, ALU_WAIT and TX_PUSH.
REQ-023 SHALL run a timeout counter that clears on entry to any state and on each accepted byte, and increments otherwise in all non-IDLE states except TX_PUSH.
REQ-024 SHALL, when the counter reaches TIMEOUT, go to IDLE, pulse ERR, and force EN, Gate_En, RdEn and WrEn to 0.
REQ-025 SHALL give an accepted byte priority over timeout expiry in the same cycle.
REQ-026 SHALL give OUT_VALID or Rd_Valid priority over timeout expiry in the same cycle.
REQ-027 SHALL hold Addr, Wr_D and FUN at their last values outside write, read and function cycles.

Reset
REQ-028 SHALL, while RST is low, force state IDLE, all counters 0, and every output 0 asynchronously.
REQ-029 SHALL abort any operation in progress on a reset asserted mid-operation, with no residual WR_INC or WrEn after reset release.

Structure
REQ-030 SHALL place the command codes (0xAA, 0xBB, 0xCC, 0xDD) and the state encoding in shared package sys_ctrl_pkg.
REQ-031 SHALL contain one sub-module, tx_serializer (ALU_W-to-DATA_W byte shifter with push handshake); all other logic stays in cmd_ctrl.

Verification
REQ-032 SHALL verify register write: bytes AA, 05, 3C -> one WrEn cycle with Addr = 5, Wr_D = 0x3C; BUSY low afterwards.
REQ-033 SHALL verify register read: bytes BB, 02 with Rd_DATA = 0x7E returned -> one RdEn pulse, then one WR_INC with WR_DATA = 0x7E.
REQ-034 SHALL verify an ALU op: bytes CC, 0A, 0B, 02 with ALU_OUT = 0x006E -> writes to Addr 0 and Addr 1, EN rises 2 cycles after Gate_En, then pushes 0x6E then 0x00.
REQ-035 SHALL verify backpressure: FIFO_FULL high for 5 cycles during the 0xDD op with ALU_OUT = 0xABCD -> pushes 0xCD then 0xAB only, no duplicates.
REQ-036 SHALL verify timeout: bytes AA then silence, with TIMEOUT = 15 -> ERR pulse after 15 cycles, IDLE, and no WrEn.
REQ-037 SHALL verify unknown command and reset mid-operation: byte 0x55 -> ERR pulse, stays IDLE; RST low during ALU_WAIT -> all outputs 0 at once.
